// File: rtl/header_extraction_pkg.sv
// Shared definitions for the receive-side header extraction stage.
// Default geometry: 512-bit beats carrying a 112-bit (14-byte) header.
// State encodings are one-hot so each state is a single flop bit.
package header_extraction_pkg;

  localparam int DEF_BITS_PER_BEAT = 512;
  localparam int DEF_HEADER_SIZE   = 112;

  // Derived constants for the default geometry.
  localparam int BB           = DEF_BITS_PER_BEAT / 8;
  localparam int HB           = DEF_HEADER_SIZE / 8;
  localparam int PAYLOAD_BITS = DEF_BITS_PER_BEAT - DEF_HEADER_SIZE;

  typedef enum logic [7:0] {
    ST_HEADER  = 8'h01,
    ST_PAYLOAD = 8'h02,
    ST_FLUSH   = 8'h04
  } state_e;

endpackage

// File: rtl/header_extraction_axis_output_register.sv
// Single-entry AXI-Stream register slice (data/keep/last with valid/ready).
// Latency: one cycle from an accepted input to out_vld_o.
// Backpressure: in_rdy_o = empty or draining this cycle; contents hold while stalled.
module axis_output_register #(
  parameter int DATA_W = 512,
  parameter int KEEP_W = DATA_W / 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_vld_i,
  output logic              in_rdy_o,
  input  logic [DATA_W-1:0] in_dat_i,
  input  logic [KEEP_W-1:0] in_keep_i,
  input  logic              in_last_i,
  output logic              out_vld_o,
  input  logic              out_rdy_i,
  output logic [DATA_W-1:0] out_dat_o,
  output logic [KEEP_W-1:0] out_keep_o,
  output logic              out_last_o
);

  logic              vld_q, vld_d;
  logic [DATA_W-1:0] dat_q, dat_d;
  logic [KEEP_W-1:0] keep_q, keep_d;
  logic              last_q, last_d;

  // The slot can take a new beat when empty or when the current one leaves now.
  assign in_rdy_o = !vld_q || out_rdy_i;

  // Next-state: load on a handshake, otherwise hold (and drop valid once drained).
  always_comb begin
    vld_d  = vld_q;
    dat_d  = dat_q;
    keep_d = keep_q;
    last_d = last_q;
    if (in_rdy_o) begin
      vld_d = in_vld_i;
      if (in_vld_i) begin
        dat_d  = in_dat_i;
        keep_d = in_keep_i;
        last_d = in_last_i;
      end
    end
  end

  // Register slot, cleared on reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_q  <= 1'b0;
      dat_q  <= '0;
      keep_q <= '0;
      last_q <= 1'b0;
    end else begin
      vld_q  <= vld_d;
      dat_q  <= dat_d;
      keep_q <= keep_d;
      last_q <= last_d;
    end
  end

  assign out_vld_o  = vld_q;
  assign out_dat_o  = dat_q;
  assign out_keep_o = keep_q;
  assign out_last_o = last_q;

endmodule

// File: rtl/header_extraction.sv
// Strips a fixed header from each AXI-Stream packet, shifts payload to lane 0, header on sideband.
// Latency: one cycle (single output register); a spill-over FLUSH beat costs one upstream bubble.
// Backpressure: tready_out = !FLUSH & output register free. Optional: HEADER_EXTRACTION_RUNT_CHECK_EN.
module header_extraction
  import header_extraction_pkg::*;
#(
  parameter int BITS_PER_BEAT = DEF_BITS_PER_BEAT,
  parameter int HEADER_SIZE   = DEF_HEADER_SIZE
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       tvalid_in,
  output logic                       tready_out,
  input  logic [BITS_PER_BEAT-1:0]   tdata_in,
  input  logic                       tlast_in,
  input  logic [BITS_PER_BEAT/8-1:0] tkeep_in,
  output logic                       tvalid_out,
  input  logic                       tready_in,
  output logic [BITS_PER_BEAT-1:0]   tdata_out,
  output logic                       tlast_out,
  output logic [BITS_PER_BEAT/8-1:0] tkeep_out,
  output logic [HEADER_SIZE-1:0]     header_data,
`ifdef HEADER_EXTRACTION_RUNT_CHECK_EN
  output logic                       runt_error,
`endif
  output logic                       header_valid
);

  // Geometry for this instance (package constants describe the default build).
  localparam int NB  = BITS_PER_BEAT / 8;
  localparam int NH  = HEADER_SIZE / 8;
  localparam int PLD = BITS_PER_BEAT - HEADER_SIZE;

  state_e                   state_q, state_d;
  logic [PLD-1:0]           leftover_q, leftover_d;
  logic [NB-NH-1:0]         lo_keep_q, lo_keep_d;
  logic [HEADER_SIZE-1:0]   header_q, header_d;
  logic                     hdr_vld_q, hdr_vld_d;

  logic                     out_vld;
  logic                     out_rdy;
  logic [BITS_PER_BEAT-1:0] out_dat;
  logic [NB-1:0]            out_keep;
  logic                     out_last;

  logic                     accept;
  logic                     tail_any;
  logic                     is_runt;

`ifdef HEADER_EXTRACTION_RUNT_CHECK_EN
  logic                     runt_q, runt_d;
  // A single-beat packet that does not even cover the header is a runt.
  assign is_runt = tlast_in && !(&tkeep_in[NH-1:0]);
`else
  assign is_runt = 1'b0;
`endif

  // No new beat is taken while a flush beat is pending or the output is blocked.
  assign tready_out = (state_q != ST_FLUSH) && out_rdy;
  assign accept     = tvalid_in && tready_out;
  // Bytes beyond the header lane range spill into the next output beat.
  assign tail_any   = |tkeep_in[NB-1:NH];

  // Next-state, leftover/header capture and output-beat assembly.
  always_comb begin
    state_d    = state_q;
    leftover_d = leftover_q;
    lo_keep_d  = lo_keep_q;
    header_d   = header_q;
    hdr_vld_d  = 1'b0;
    out_vld    = 1'b0;
    out_dat    = '0;
    out_keep   = '0;
    out_last   = 1'b0;
`ifdef HEADER_EXTRACTION_RUNT_CHECK_EN
    runt_d     = 1'b0;
`endif
    case (state_q)
      ST_HEADER: begin
        if (accept) begin
          if (is_runt) begin
`ifdef HEADER_EXTRACTION_RUNT_CHECK_EN
            runt_d = 1'b1;
`endif
          end else begin
            header_d   = tdata_in[HEADER_SIZE-1:0];
            hdr_vld_d  = 1'b1;
            leftover_d = tdata_in[BITS_PER_BEAT-1 -: PLD];
            lo_keep_d  = tkeep_in[NB-1:NH];
            if (!tlast_in) begin
              state_d = ST_PAYLOAD;
            end else if (tail_any) begin
              state_d = ST_FLUSH;
            end
            // Header-only packet: nothing to emit, stay in HEADER.
          end
        end
      end
      ST_PAYLOAD: begin
        if (accept) begin
          out_vld    = 1'b1;
          out_dat    = {tdata_in[HEADER_SIZE-1:0], leftover_q};
          out_keep   = {tkeep_in[NH-1:0], lo_keep_q};
          out_last   = tlast_in && !tail_any;
          leftover_d = tdata_in[BITS_PER_BEAT-1 -: PLD];
          lo_keep_d  = tkeep_in[NB-1:NH];
          if (tlast_in) begin
            state_d = tail_any ? ST_FLUSH : ST_HEADER;
          end
        end
      end
      ST_FLUSH: begin
        if (out_rdy) begin
          out_vld  = 1'b1;
          out_dat  = {{HEADER_SIZE{1'b0}}, leftover_q};
          out_keep = {{NH{1'b0}}, lo_keep_q};
          out_last = 1'b1;
          state_d  = ST_HEADER;
        end
      end
      default: state_d = ST_HEADER;
    endcase
  end

  // State, leftover and sideband registers; reset discards any partial packet.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_HEADER;
      leftover_q <= '0;
      lo_keep_q  <= '0;
      header_q   <= '0;
      hdr_vld_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      leftover_q <= leftover_d;
      lo_keep_q  <= lo_keep_d;
      header_q   <= header_d;
      hdr_vld_q  <= hdr_vld_d;
    end
  end

`ifdef HEADER_EXTRACTION_RUNT_CHECK_EN
  // One-cycle runt indication.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      runt_q <= 1'b0;
    end else begin
      runt_q <= runt_d;
    end
  end
  assign runt_error = runt_q;
`endif

  assign header_data  = header_q;
  assign header_valid = hdr_vld_q;

  axis_output_register #(
    .DATA_W (BITS_PER_BEAT),
    .KEEP_W (NB)
  ) u_out_reg (
    .clk_i      (clock),
    .rst_i      (reset),
    .in_vld_i   (out_vld),
    .in_rdy_o   (out_rdy),
    .in_dat_i   (out_dat),
    .in_keep_i  (out_keep),
    .in_last_i  (out_last),
    .out_vld_o  (tvalid_out),
    .out_rdy_i  (tready_in),
    .out_dat_o  (tdata_out),
    .out_keep_o (tkeep_out),
    .out_last_o (tlast_out)
  );

endmodule

// File: tb/tb_header_extraction.sv
// Randomized packet bench for header_extraction with a byte-level reference model.
// Expected headers/beats are derived from packet bytes: header = first HB bytes,
// payload = remaining bytes cut into BB-byte beats starting at lane 0.
module tb_header_extraction;
  import header_extraction_pkg::*;

  localparam int W = DEF_BITS_PER_BEAT;

  typedef struct packed {
    logic [W-1:0]  d;
    logic [BB-1:0] k;
    logic          l;
  } beat_t;

  logic                          clock = 1'b0;
  logic                          reset;
  logic                          tvalid_in;
  logic                          tready_out;
  logic [W-1:0]                  tdata_in;
  logic                          tlast_in;
  logic [BB-1:0]                 tkeep_in;
  logic                          tvalid_out;
  logic                          tready_in;
  logic [W-1:0]                  tdata_out;
  logic                          tlast_out;
  logic [BB-1:0]                 tkeep_out;
  logic [DEF_HEADER_SIZE-1:0]    header_data;
  logic                          header_valid;
`ifdef HEADER_EXTRACTION_RUNT_CHECK_EN
  logic                          runt_error;
  int                            runt_cnt = 0;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int rdy_mode = 0;   // 0: always ready, 1: random stalls, 2: never ready
  bit mon_en   = 1'b1;
  bit bub_en   = 1'b0;
  int bub_cnt  = 0;

  logic [DEF_HEADER_SIZE-1:0] exp_hdr[$];
  beat_t                      exp_beat[$];

  header_extraction #(
    .BITS_PER_BEAT (DEF_BITS_PER_BEAT),
    .HEADER_SIZE   (DEF_HEADER_SIZE)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .tvalid_in    (tvalid_in),
    .tready_out   (tready_out),
    .tdata_in     (tdata_in),
    .tlast_in     (tlast_in),
    .tkeep_in     (tkeep_in),
    .tvalid_out   (tvalid_out),
    .tready_in    (tready_in),
    .tdata_out    (tdata_out),
    .tlast_out    (tlast_out),
    .tkeep_out    (tkeep_out),
    .header_data  (header_data),
`ifdef HEADER_EXTRACTION_RUNT_CHECK_EN
    .runt_error   (runt_error),
`endif
    .header_valid (header_valid)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Waits until the currently driven beat is taken; returns 0 on timeout.
  task automatic wait_accept(output bit ok);
    int guard = 0;
    ok = 1'b0;
    while (!ok && guard < 200) begin
      @(negedge clock);
      ok = tready_out;
      @(posedge clock);
      #1;
      guard++;
    end
    if (!ok) chk("accept_timeout", 0, 1);
  endtask

  // Builds a packet of len random bytes, records the expected result, drives it.
  task automatic send_pkt(input int len, input int gap_max);
    logic [7:0] pk[$];
    logic [DEF_HEADER_SIZE-1:0] h;
    beat_t e;
    int pl, nb, nbeats;
    bit ok;
    for (int i = 0; i < len; i++) pk.push_back(8'($urandom));
    if (len >= HB) begin
      h = '0;
      for (int i = 0; i < HB; i++) h[i*8 +: 8] = pk[i];
      exp_hdr.push_back(h);
      pl = len - HB;
      nb = (pl + BB - 1) / BB;
      for (int b = 0; b < nb; b++) begin
        e = '0;
        for (int j = 0; j < BB; j++) begin
          if (b*BB + j < pl) begin
            e.d[j*8 +: 8] = pk[HB + b*BB + j];
            e.k[j] = 1'b1;
          end
        end
        e.l = (b == nb - 1);
        exp_beat.push_back(e);
      end
    end
    nbeats = (len + BB - 1) / BB;
    for (int b = 0; b < nbeats; b++) begin
      tvalid_in = 1'b0;
      repeat ($urandom_range(0, gap_max)) begin
        @(posedge clock);
        #1;
      end
      tdata_in = '0;
      tkeep_in = '0;
      for (int j = 0; j < BB; j++) begin
        if (b*BB + j < len) begin
          tdata_in[j*8 +: 8] = pk[b*BB + j];
          tkeep_in[j] = 1'b1;
        end
      end
      tlast_in  = (b == nbeats - 1);
      tvalid_in = 1'b1;
      wait_accept(ok);
    end
    tvalid_in = 1'b0;
    tlast_in  = 1'b0;
  endtask

  task automatic wait_drain();
    int guard = 0;
    while ((exp_beat.size() != 0 || exp_hdr.size() != 0) && guard < 1000) begin
      @(posedge clock);
      #1;
      guard++;
    end
    if (guard >= 1000) chk("drain_timeout", 0, 1);
    repeat (2) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Downstream ready generator.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      case (rdy_mode)
        0:       tready_in = 1'b1;
        1:       tready_in = ($urandom_range(0, 3) != 0);
        default: tready_in = 1'b0;
      endcase
    end
  end

  // Scoreboard: every presented output beat must equal the head of the expected queue.
  initial begin
    beat_t e;
    logic [W-1:0] m;
    forever begin
      @(negedge clock);
      if (!reset && mon_en) begin
        if (header_valid) begin
          if (exp_hdr.size() == 0) chk("hdr_extra", 1, 0);
          else chk("hdr", W'(header_data), W'(exp_hdr.pop_front()));
        end
        if (tvalid_out) begin
          if (exp_beat.size() == 0) chk("beat_extra", 1, 0);
          else begin
            e = exp_beat[0];
            m = '0;
            for (int j = 0; j < BB; j++) if (e.k[j]) m[j*8 +: 8] = 8'hFF;
            chk("dat", tdata_out & m, e.d);
            chk("keep", W'(tkeep_out), W'(e.k));
            chk("last", W'(tlast_out), W'(e.l));
            if (tready_in) void'(exp_beat.pop_front());
          end
        end
        if (bub_en && !tready_out) bub_cnt++;
`ifdef HEADER_EXTRACTION_RUNT_CHECK_EN
        if (runt_error) runt_cnt++;
`endif
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    reset     = 1'b1;
    tvalid_in = 1'b0;
    tdata_in  = '0;
    tkeep_in  = '0;
    tlast_in  = 1'b0;
    tready_in = 1'b1;
    #1;
    chk("rst_tvalid_out", W'(tvalid_out), 0);
    chk("rst_tready_out", W'(tready_out), 1);
    chk("rst_hdr_valid", W'(header_valid), 0);
    chk("rst_hdr_data", W'(header_data), 0);
    chk("rst_tdata_out", tdata_out, 0);
    chk("rst_tkeep_out", W'(tkeep_out), 0);
    chk("rst_tlast_out", W'(tlast_out), 0);
`ifdef HEADER_EXTRACTION_RUNT_CHECK_EN
    chk("rst_runt", W'(runt_error), 0);
`endif
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;

    // Directed: single full beat (flush path), 78-byte (no flush), 128-byte bubble.
    rdy_mode = 0;
    send_pkt(64, 0);
    wait_drain();
    send_pkt(78, 0);
    wait_drain();
    bub_cnt = 0;
    bub_en  = 1'b1;
    send_pkt(128, 0);
    repeat (4) begin
      @(posedge clock);
      #1;
    end
    bub_en = 1'b0;
    chk("flush_bubble", W'(bub_cnt), 1);
    wait_drain();
    // Header-only packet followed back-to-back by a full beat.
    send_pkt(HB, 0);
    send_pkt(64, 0);
    wait_drain();
    // Four-beat packet under random downstream stalls.
    rdy_mode = 1;
    send_pkt(256, 0);
    wait_drain();

    // Reset in the middle of a stalled packet.
    mon_en   = 1'b0;
    rdy_mode = 2;
    repeat (2) begin
      @(posedge clock);
      #1;
    end
    for (int b = 0; b < 2; b++) begin
      tdata_in  = {16{32'($urandom)}};
      tkeep_in  = '1;
      tlast_in  = 1'b0;
      tvalid_in = 1'b1;
      wait_accept(ok);
    end
    tdata_in = {16{32'($urandom)}};
    @(negedge clock);
    chk("stall_tready_out", W'(tready_out), 0);
    chk("stall_tvalid_out", W'(tvalid_out), 1);
    #2;
    reset = 1'b1;
    tvalid_in = 1'b0;
    #1;
    chk("mid_rst_tvalid_out", W'(tvalid_out), 0);
    chk("mid_rst_tready_out", W'(tready_out), 1);
    chk("mid_rst_hdr_data", W'(header_data), 0);
    chk("mid_rst_tdata_out", tdata_out, 0);
    chk("mid_rst_tkeep_out", W'(tkeep_out), 0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    exp_hdr.delete();
    exp_beat.delete();
    mon_en   = 1'b1;
    rdy_mode = 1;
    send_pkt(150, 1);
    wait_drain();

`ifdef HEADER_EXTRACTION_RUNT_CHECK_EN
    rdy_mode = 0;
    runt_cnt = 0;
    send_pkt(10, 0);
    repeat (3) begin
      @(posedge clock);
      #1;
    end
    chk("runt_pulse", W'(runt_cnt), 1);
    send_pkt(64, 0);
    wait_drain();
`endif

    // Random packets, lengths from header-only up to five beats.
    for (int p = 0; p < 40; p++) begin
      rdy_mode = $urandom_range(0, 1);
      send_pkt($urandom_range(HB, 5*BB), $urandom_range(0, 2));
    end
    wait_drain();
    chk("left_hdr", W'(exp_hdr.size()), 0);
    chk("left_beats", W'(exp_beat.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
